// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multi-cycle multiply/divide engine.
// Owns HI/LO, runs MT/MF locally and stalls D while an operation is in flight.
module md_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int OPW     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] e_op,
    input  logic [31:0]    e_a,
    input  logic [31:0]    e_b,
    input  logic           req,
    input  logic           d_is_md,
    output logic           d_stall,
    output logic           busy,
    output logic [31:0]    e_mdout,
    output logic           md_valid,
    input  logic           md_ready,
    output logic [1:0]     md_op,
    output logic [31:0]    md_a,
    output logic [31:0]    md_b,
    input  logic           md_done,
    input  logic [31:0]    md_hi,
    input  logic [31:0]    md_lo,
    output logic           err_timeout
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state;
    logic [31:0]   hi, lo;
    logic [31:0]   a_q, b_q;
    logic [1:0]    op_q;
    logic [TW-1:0] timer;

    logic          is_issue_op, issue, done_acc;
    logic [1:0]    e_mdop;

    always_comb begin
        is_issue_op = 1'b0;
        e_mdop      = 2'd0;
        case (e_op)
            OPW'(1): begin is_issue_op = 1'b1; e_mdop = 2'd0; end
            OPW'(2): begin is_issue_op = 1'b1; e_mdop = 2'd1; end
            OPW'(3): begin is_issue_op = 1'b1; e_mdop = 2'd2; end
            OPW'(4): begin is_issue_op = 1'b1; e_mdop = 2'd3; end
            default: ;
        endcase
    end

    // Issue straight from E so an engine that is ready takes the op with no bubble.
    assign issue    = (state == IDLE) && is_issue_op && !req;
    assign done_acc = (state == WAIT) && md_done;

    assign md_valid = issue || (state == REQ);
    assign md_op    = issue ? e_mdop : op_q;
    assign md_a     = issue ? e_a : a_q;
    assign md_b     = issue ? e_b : b_q;
    assign busy     = (state != IDLE);
    assign d_stall  = d_is_md && (busy || issue);

    always_comb begin
        e_mdout = 32'd0;
        if (e_op == OPW'(5))      e_mdout = done_acc ? md_hi : hi;
        else if (e_op == OPW'(6)) e_mdout = done_acc ? md_lo : lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hi          <= 32'd0;
            lo          <= 32'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= 2'd0;
            timer       <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        op_q  <= e_mdop;
                        a_q   <= e_a;
                        b_q   <= e_b;
                        timer <= '0;
                        state <= md_ready ? WAIT : REQ;
                    end else if (!req && e_op == OPW'(7)) begin
                        hi <= e_a;
                    end else if (!req && e_op == OPW'(8)) begin
                        lo <= e_a;
                    end
                end
                // The op is committed once requested; a late flush does not retract it.
                REQ: begin
                    if (md_ready) begin
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (md_done) begin
                        hi    <= md_hi;
                        lo    <= md_lo;
                        state <= IDLE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed, table-driven bench for md_issue_ctrl plus hand sequences for timeout and reset.
module tb_md_issue_ctrl;
    logic        clk, rst_n;
    logic [3:0]  e_op;
    logic [31:0] e_a, e_b, md_hi, md_lo;
    logic        req, d_is_md, md_ready, md_done;
    logic        d_stall, busy, md_valid, err_timeout;
    logic [31:0] e_mdout, md_a, md_b;
    logic [1:0]  md_op;

    int checks = 0;
    int errors = 0;

    md_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .e_op(e_op), .e_a(e_a), .e_b(e_b), .req(req),
        .d_is_md(d_is_md), .d_stall(d_stall), .busy(busy), .e_mdout(e_mdout),
        .md_valid(md_valid), .md_ready(md_ready), .md_op(md_op), .md_a(md_a),
        .md_b(md_b), .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        rq, dmd, rdy, dn;
        logic [31:0] hin, lin;
        logic        x_stall, x_busy, x_vld;
        logic [1:0]  x_mop;
        logic [31:0] x_out, x_ma, x_mb;
    } vec_t;

    function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic rq,
                                logic dmd, logic rdy, logic dn, logic [31:0] hin, logic [31:0] lin,
                                logic xs, logic xb, logic xv, logic [1:0] xm,
                                logic [31:0] xo, logic [31:0] xa, logic [31:0] xbb);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.rq = rq; v.dmd = dmd; v.rdy = rdy; v.dn = dn;
        v.hin = hin; v.lin = lin; v.x_stall = xs; v.x_busy = xb; v.x_vld = xv;
        v.x_mop = xm; v.x_out = xo; v.x_ma = xa; v.x_mb = xbb;
        return v;
    endfunction

    task automatic drive(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic rq,
                         logic dmd, logic rdy, logic dn, logic [31:0] hin, logic [31:0] lin);
        @(posedge clk);
        #1;
        e_op = op; e_a = a; e_b = b; req = rq; d_is_md = dmd;
        md_ready = rdy; md_done = dn; md_hi = hin; md_lo = lin;
        @(negedge clk);
    endtask

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // {stall,busy,valid,err,op,mdout,a,b}
    function automatic logic [127:0] outs();
        return {26'd0, d_stall, busy, md_valid, err_timeout, md_op, e_mdout, md_a, md_b};
    endfunction

    function automatic logic [127:0] pack(logic s, logic bsy, logic v, logic er, logic [1:0] m,
                                          logic [31:0] o, logic [31:0] a, logic [31:0] b);
        return {26'd0, s, bsy, v, er, m, o, a, b};
    endfunction

    vec_t vt[$];
    localparam logic [31:0] F = 32'hFFFF_FFFF;

    initial begin
        rst_n = 1'b0;
        e_op = 0; e_a = 0; e_b = 0; req = 0; d_is_md = 0;
        md_ready = 0; md_done = 0; md_hi = 0; md_lo = 0;
        #12;
        chk("reset_outs", outs(), pack(0, 0, 0, 0, 0, 0, 0, 0));
        #5 rst_n = 1'b1;

        //       op  a            b      rq dmd rdy dn hin    lin           st bsy vld mop out            ma           mb
        vt.push_back(mk(0, 0,        0,     0, 0, 0, 0, 0,     0,            0, 0, 0, 0, 0,             0,           0));
        vt.push_back(mk(7, 32'h1234, 0,     0, 1, 0, 0, 0,     0,            0, 0, 0, 0, 0,             0,           0));
        vt.push_back(mk(8, 32'h5678, 0,     0, 1, 0, 0, 0,     0,            0, 0, 0, 0, 0,             0,           0));
        vt.push_back(mk(5, 0,        0,     0, 1, 0, 0, 0,     0,            0, 0, 0, 0, 32'h1234,      0,           0));
        vt.push_back(mk(6, 0,        0,     0, 0, 0, 0, 0,     0,            0, 0, 0, 0, 32'h5678,      0,           0));
        // MULT accepted immediately, MFLO waiting in D
        vt.push_back(mk(1, F,        2,     0, 1, 1, 0, 0,     0,            1, 0, 1, 0, 0,             F,           2));
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(0, 0,    0,     0, 1, 0, 0, 0,     0,            1, 1, 0, 0, 0,             F,           2));
        vt.push_back(mk(0, 0,        0,     0, 1, 0, 1, F,     32'hFFFF_FFFE,1, 1, 0, 0, 0,             F,           2));
        vt.push_back(mk(6, 0,        0,     0, 0, 0, 0, 0,     0,            0, 0, 0, 0, 32'hFFFF_FFFE, F,           2));
        vt.push_back(mk(5, 0,        0,     0, 0, 0, 0, 0,     0,            0, 0, 0, 0, F,             F,           2));
        // DIVU held off by the engine; operands must stay put even as E changes
        vt.push_back(mk(4, 100,      7,     0, 0, 0, 0, 0,     0,            0, 0, 1, 3, 0,             100,         7));
        vt.push_back(mk(0, 32'hDEAD, 32'hBEEF, 0, 0, 0, 0, 0,  0,            0, 1, 1, 3, 0,             100,         7));
        vt.push_back(mk(0, 32'hDEAD, 32'hBEEF, 1, 1, 0, 0, 0,  0,            1, 1, 1, 3, 0,             100,         7));
        vt.push_back(mk(0, 32'hDEAD, 32'hBEEF, 0, 0, 1, 0, 0,  0,            0, 1, 1, 3, 0,             100,         7));
        // done in WAIT forwarded to MFHI
        vt.push_back(mk(5, 0,        0,     0, 0, 0, 1, 32'h11, 32'h22,      0, 1, 0, 3, 32'h11,        100,         7));
        vt.push_back(mk(6, 0,        0,     0, 0, 0, 0, 0,     0,            0, 0, 0, 3, 32'h22,        100,         7));
        // flushed MULT and MTLO have no effect; stray done in IDLE ignored
        vt.push_back(mk(1, 5,        6,     1, 1, 1, 0, 0,     0,            0, 0, 0, 3, 0,             100,         7));
        vt.push_back(mk(0, 0,        0,     0, 0, 0, 1, 32'hAAAA, 32'hBBBB,  0, 0, 0, 3, 0,             100,         7));
        vt.push_back(mk(8, 32'h9999, 0,     1, 0, 0, 0, 0,     0,            0, 0, 0, 3, 0,             100,         7));
        vt.push_back(mk(6, 0,        0,     0, 0, 0, 0, 0,     0,            0, 0, 0, 3, 32'h22,        100,         7));
        vt.push_back(mk(5, 0,        0,     0, 0, 0, 0, 0,     0,            0, 0, 0, 3, 32'h11,        100,         7));

        foreach (vt[i]) begin
            drive(vt[i].op, vt[i].a, vt[i].b, vt[i].rq, vt[i].dmd, vt[i].rdy, vt[i].dn,
                  vt[i].hin, vt[i].lin);
            chk($sformatf("vec%0d", i), outs(),
                pack(vt[i].x_stall, vt[i].x_busy, vt[i].x_vld, 1'b0, vt[i].x_mop,
                     vt[i].x_out, vt[i].x_ma, vt[i].x_mb));
        end

        // Timeout: accepted MULT, engine never answers
        begin
            int nbusy = 0;
            bit fell  = 0;
            drive(1, 3, 4, 0, 0, 1, 0, 0, 0);
            for (int c = 0; c < 200 && !fell; c++) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
                if (busy) nbusy++;
                else fell = 1;
            end
            chk("timeout_fell", {127'd0, fell}, 128'd1);
            chk("timeout_busy_cycles", 128'(nbusy), 128'd64);
            chk("timeout_err", {127'd0, err_timeout}, 128'd1);
            drive(0, 0, 0, 0, 0, 0, 1, 32'h5555, 32'h6666);
            drive(5, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("timeout_hi", 128'(e_mdout), 128'h11);
            drive(6, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("timeout_lo", 128'(e_mdout), 128'h22);
            chk("timeout_sticky", {127'd0, err_timeout}, 128'd1);
        end

        // Reset mid-WAIT, then a stale done pulse
        drive(2, 8, 9, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_reset_busy", {127'd0, busy}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", outs(), pack(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h77, 32'h88);
        chk("stale_done_busy", {127'd0, busy}, 128'd0);
        drive(5, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_reset_hi", 128'(e_mdout), 128'd0);
        drive(6, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_reset_lo", 128'(e_mdout), 128'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_reset_outs", outs(), pack(0, 0, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
